andrewm_uart_to_parallel: RTL and testbench
===========================================

Name: andrewm_uart_to_parallel

Overview:
- UART 8N1 receiver: deserializes a serial line into a parallel byte and holds it for a consumer.
- Receive-side counterpart to the team's parallel-to-UART transmitter.
- Default bit period matches the transmitter: 256 clk cycles per bit, LSB first, idle-high line.
- Output byte is held with a valid/ack handshake; framing and overrun errors are reported as sticky flags.

Parameters:
- CLKS_PER_BIT, 256: clk cycles per UART bit; must be an even number ≥ 4.
- HALF_BIT, CLKS_PER_BIT/2: derived; offset from the start edge to the mid-bit sample point.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- rx  input  1  serial line; asynchronous to clk; idle high.
- rd_ack  input  1  consumer acknowledges data_out; sampled on posedge.
- err_clr  input  1  clears frame_err and overrun.
- data_out  output  8  last good received byte.
- data_valid  output  1  data_out holds an unacknowledged byte.
- frame_err  output  1  sticky; a stop bit was sampled as 0.
- overrun  output  1  sticky; a good byte completed while data_valid=1 and rd_ack=0.
- busy  output  1  FSM is not in IDLE.

Behaviour:
- Reset (reset=0, async):
  - data_out=0x00; data_valid, frame_err, overrun and busy all 0.
  - Both synchronizer flops set to 1; FSM to IDLE; counters and shift register cleared.
  - Reset mid-frame abandons the frame; no partial byte is delivered.
- Input sync: rx passes through 2 flops to give rx_s. A pin level first captured at edge P is visible to the FSM at edge P+2.
- Bit counter: width sufficient for CLKS_PER_BIT-1. Bit index: 0..7, 3 bits.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE:
  - rx_s=0 at edge E0 → START; counter loaded with HALF_BIT-1.
  - busy=1 from the cycle after E0 onward.
- START:
  - Counter decrements to 0; the start bit is sampled at E0+HALF_BIT.
  - rx_s=1 → false start, go to IDLE with no flags changed.
  - rx_s=0 → DATA; counter loaded with CLKS_PER_BIT-1; bit index=0.
- DATA:
  - Bit i is sampled at E0+HALF_BIT+(i+1)*CLKS_PER_BIT and shifted in LSB first (shift right, insert at bit 7).
  - After bit 7 → STOP; counter reloaded.
- STOP: stop bit is sampled at E0+HALF_BIT+9*CLKS_PER_BIT.
  - rx_s=1 (good byte):
    - If data_valid=0, or rd_ack=1 in the same cycle: data_out←shift register, data_valid=1.
    - Otherwise: overrun←1; data_out and data_valid are unchanged; the new byte is dropped.
    - Go to IDLE; a new start edge is accepted from the next cycle.
  - rx_s=0: frame_err←1; data_out and data_valid unchanged; go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s=1, then IDLE. A break or held-low line never produces spurious frames.
- Handshake:
  - data_valid falls on the edge where rd_ack=1.
  - rd_ack while data_valid=0 is ignored.
  - Ack and new-byte load in the same cycle → data_valid stays 1, data_out takes the new byte.
- err_clr clears both flags on the next edge. If an error sets in the same cycle, the set wins.
- rx is ignored while the FSM is in START, DATA or STOP, except at the sample points.

Test Plan (CLKS_PER_BIT=16 for sim; also run one case at the default 256):
- Send 0xA5 with a good stop bit → data_valid rises at E0+8+9*16; data_out=0xA5; frame_err=0; overrun=0; busy returns to 0.
- Hold data_valid and pulse rd_ack for 1 cycle → data_valid=0 on the next edge; data_out stays 0xA5. Send 0x3C with rd_ack asserted at stop-sample → data_valid stays 1, data_out=0x3C.
- Glitch rx low for 5 cycles (less than HALF_BIT) → no data_valid, no flags; busy pulses then returns 0; a following 0x5A is received correctly.
- Send 0xFF with stop bit 0, then hold rx low for 40 cycles → frame_err=1, data_valid unchanged, FSM stays in WAIT_HIGH with no new frame. Release rx, pulse err_clr → frame_err=0.
- Send 0x11 then 0x22 with no ack → data_out=0x11, overrun=1. After ack and err_clr, send 0x33 → data_out=0x33, overrun=0.
- Assert reset=0 asynchronously mid-DATA of 0x96 → all outputs at reset values immediately (before the next posedge). Release, then send 0x96 → received correctly.

Source files
------------

// File: rtl/andrewm_uart_to_parallel.sv
// UART 8N1 receiver: two-flop synchronised rx, mid-bit sampling, LSB first.
// The received byte is held under a valid/ack handshake; framing and overrun errors are sticky flags.
module andrewm_uart_to_parallel #(
  parameter int CLKS_PER_BIT = 256,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rd_ack,
  input  logic       err_clr,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             rx_p0, rx_s;
  logic             load_byte, set_fe, set_ov;
  logic             tick;

  assign tick = (cnt == '0);
  assign busy = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    load_byte   = 1'b0;
    set_fe      = 1'b0;
    set_ov      = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt   = DATA;
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          shreg_nxt   = {rx_s, shreg[7:1]};
          cnt_nxt     = FULL_LOAD;
          bit_idx_nxt = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - 1'b1;
        end else if (rx_s) begin
          state_nxt = IDLE;
          // A same-cycle ack frees the holding register for the new byte.
          if (!data_valid || rd_ack) load_byte = 1'b1;
          else                       set_ov    = 1'b1;
        end else begin
          set_fe    = 1'b1;
          state_nxt = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Synchroniser stage and FSM/datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_p0      <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_p0      <= rx;
      rx_s       <= rx_p0;
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      if (load_byte) data_out <= shreg;
      data_valid <= load_byte | (data_valid & ~rd_ack);
      frame_err  <= set_fe | (frame_err & ~err_clr);
      overrun    <= set_ov | (overrun & ~err_clr);
    end
  end

endmodule

// File: tb/tb_andrewm_uart_to_parallel.sv
// Directed bench for the UART receiver: a fast instance (16 clk/bit) plus one frame at the default 256.
module tb_andrewm_uart_to_parallel;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx, rd_ack, err_clr;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;
  logic       rx2, rd_ack2, err_clr2;
  logic [7:0] data_out2;
  logic       data_valid2, frame_err2, overrun2, busy2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  andrewm_uart_to_parallel #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_ack(rd_ack), .err_clr(err_clr),
    .data_out(data_out), .data_valid(data_valid), .frame_err(frame_err),
    .overrun(overrun), .busy(busy)
  );

  andrewm_uart_to_parallel dut256 (
    .clk(clk), .reset(reset), .rx(rx2), .rd_ack(rd_ack2), .err_clr(err_clr2),
    .data_out(data_out2), .data_valid(data_valid2), .frame_err(frame_err2),
    .overrun(overrun2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input bit slow);
    if (slow) rx2 = v;
    else      rx  = v;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit slow);
    int cpb;
    cpb = slow ? 256 : CPB;
    drive(1'b0, slow);
    edges(cpb);
    for (int i = 0; i < 8; i++) begin
      drive(b[i], slow);
      edges(cpb);
    end
    drive(stop_bit, slow);
    edges(cpb);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    edges(1);
    rd_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rx = 1'b1; rd_ack = 1'b0; err_clr = 1'b0;
    rx2 = 1'b1; rd_ack2 = 1'b0; err_clr2 = 1'b0;
    #2;
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_valid", data_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    edges(3);
    reset = 1'b1;
    edges(5);

    // Good frame 0xA5: data_valid must rise exactly on the stop-sample edge (P+154)
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        edges(154);
        chk("a5_valid_early", data_valid, 0);
        edges(1);
        chk("a5_valid_on_time", data_valid, 1);
        chk("a5_busy_idle", busy, 0);
      end
    join
    chk("a5_data", data_out, 8'hA5);
    chk("a5_frame_err", frame_err, 0);
    chk("a5_overrun", overrun, 0);

    // Handshake: ack clears valid, stray ack ignored, ack+load keeps valid
    ack_pulse();
    chk("ack_valid_low", data_valid, 0);
    chk("ack_data_held", data_out, 8'hA5);
    ack_pulse();
    chk("stray_ack_valid", data_valid, 0);
    edges(4);
    send_frame(8'h77, 1'b1, 1'b0);
    chk("b77_data", data_out, 8'h77);
    chk("b77_valid", data_valid, 1);
    edges(4);
    fork
      send_frame(8'h3C, 1'b1, 1'b0);
      begin
        edges(154);
        rd_ack = 1'b1;
        edges(1);
        rd_ack = 1'b0;
        chk("ackload_valid", data_valid, 1);
        chk("ackload_data", data_out, 8'h3C);
        chk("ackload_overrun", overrun, 0);
      end
    join

    // Short glitch is a false start
    ack_pulse();
    rx = 1'b0;
    edges(5);
    rx = 1'b1;
    chk("glitch_busy", busy, 1);
    edges(10);
    chk("glitch_busy_done", busy, 0);
    chk("glitch_valid", data_valid, 0);
    chk("glitch_frame_err", frame_err, 0);
    edges(4);
    send_frame(8'h5A, 1'b1, 1'b0);
    chk("b5a_data", data_out, 8'h5A);
    chk("b5a_valid", data_valid, 1);

    // Bad stop bit then a held-low line
    ack_pulse();
    edges(4);
    send_frame(8'hFF, 1'b0, 1'b0);
    edges(40);
    chk("fe_set", frame_err, 1);
    chk("fe_valid", data_valid, 0);
    chk("fe_wait_high", busy, 1);
    rx = 1'b1;
    edges(5);
    chk("fe_released", busy, 0);
    chk("fe_sticky", frame_err, 1);
    err_clr = 1'b1;
    edges(1);
    err_clr = 1'b0;
    chk("fe_cleared", frame_err, 0);
    chk("fe_no_frame", data_valid, 0);

    // Overrun: second byte dropped while first is unacknowledged
    edges(4);
    send_frame(8'h11, 1'b1, 1'b0);
    edges(4);
    send_frame(8'h22, 1'b1, 1'b0);
    chk("ov_data_kept", data_out, 8'h11);
    chk("ov_valid", data_valid, 1);
    chk("ov_set", overrun, 1);
    rd_ack = 1'b1; err_clr = 1'b1;
    edges(1);
    rd_ack = 1'b0; err_clr = 1'b0;
    chk("ov_ack_valid", data_valid, 0);
    chk("ov_cleared", overrun, 0);
    edges(4);
    send_frame(8'h33, 1'b1, 1'b0);
    chk("b33_data", data_out, 8'h33);
    chk("b33_valid", data_valid, 1);
    chk("b33_overrun", overrun, 0);

    // Asynchronous reset mid-DATA, checked before the next clock edge
    edges(4);
    fork
      send_frame(8'h96, 1'b1, 1'b0);
      begin
        edges(60);
        chk("mid_busy", busy, 1);
        reset = 1'b0;
        #2;
        chk("arst_data_out", data_out, 8'h00);
        chk("arst_valid", data_valid, 0);
        chk("arst_frame_err", frame_err, 0);
        chk("arst_overrun", overrun, 0);
        chk("arst_busy", busy, 0);
      end
    join
    edges(3);
    reset = 1'b1;
    edges(5);
    chk("post_rst_valid", data_valid, 0);
    send_frame(8'h96, 1'b1, 1'b0);
    chk("b96_data", data_out, 8'h96);
    chk("b96_valid", data_valid, 1);
    chk("b96_frame_err", frame_err, 0);

    // Default 256 clk/bit: stop sample lands at P+2+128+9*256
    edges(4);
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        edges(2434);
        chk("slow_valid_early", data_valid2, 0);
        edges(1);
        chk("slow_valid_on_time", data_valid2, 1);
      end
    join
    chk("slow_data", data_out2, 8'hA5);
    chk("slow_frame_err", frame_err2, 0);
    chk("slow_busy", busy2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
